store_buffer: RTL

STORE_BUFFER -- requirements
Module: store_buffer

---
 rtl/rv32i_pkg.sv | 24 ++
 rtl/sb_match.sv | 50 +++++
 rtl/store_buffer.sv | 128 ++++++++++++
 3 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: data-memory size codes and the store-buffer entry.
package rv32i_pkg;

    // DMCtrl size encodings seen by the data memory port.
    localparam logic [2:0] DM_SB = 3'b000;
    localparam logic [2:0] DM_SH = 3'b001;
    localparam logic [2:0] DM_SW = 3'b010;

    // Widest address an entry can hold; narrower AW values use the low bits.
    localparam int unsigned SB_ADDR_MAX = 32;

    // One buffered store, kept exactly as presented by the MEM stage.
    typedef struct packed {
        logic [SB_ADDR_MAX-1:0] addr;
        logic [31:0]            data;
        logic [2:0]             ctrl;
    } sb_entry_t;

    // True for the three size codes a store may carry.
    function automatic logic dm_size_valid(input logic [2:0] ctrl);
        return (ctrl == DM_SB) || (ctrl == DM_SH) || (ctrl == DM_SW);
    endfunction

endpackage

// File: rtl/sb_match.sv
// Word-address match across the buffered stores with youngest-match priority.
// Slots are visited oldest to youngest starting at head, so the last hit wins.
module sb_match
    import rv32i_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 32,
    localparam int unsigned PW   = $clog2(DEPTH),
    localparam int unsigned CW   = PW + 1
) (
    input  logic                         lookup_en,
    input  logic [AW-3:0]                ld_word,
    input  logic [PW-1:0]                head,
    input  logic [CW-1:0]                count,
    input  logic [DEPTH-1:0][AW-3:0]     ent_word,
    input  logic [DEPTH-1:0][31:0]       ent_data,
    input  logic [DEPTH-1:0][2:0]        ent_ctrl,
    output logic                         fwd_hit,
    output logic [31:0]                  fwd_word,
    output logic                         ld_stall
);

    logic          any_hit;
    logic [PW-1:0] sel;
    logic [PW-1:0] slot;
    logic          sel_is_word;

    // Scan live entries in age order; keep the youngest matching slot.
    always_comb begin
        any_hit = 1'b0;
        sel     = '0;
        slot    = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            slot = head + PW'(i);
            if ((CW'(i) < count) && (ent_word[slot] == ld_word)) begin
                any_hit = 1'b1;
                sel     = slot;
            end
        end
    end

    // A full-word youngest match forwards; a partial one must wait for drain.
    always_comb begin
        sel_is_word = (ent_ctrl[sel] == DM_SW);
        fwd_hit     = lookup_en & any_hit & sel_is_word;
        ld_stall    = lookup_en & any_hit & ~sel_is_word;
        fwd_word    = fwd_hit ? ent_data[sel] : 32'h0;
    end

endmodule

// File: rtl/store_buffer.sv
// Circular store buffer between the MEM stage and the data memory port.
// Stores drain in order whenever the port is free; loads snoop for forwarding.
module store_buffer
    import rv32i_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          st_valid,
    input  logic [AW-1:0] st_addr,
    input  logic [31:0]   st_data,
    input  logic [2:0]    st_ctrl,
    output logic          st_ready,
    input  logic          ld_valid,
    input  logic [AW-1:0] ld_addr,
    output logic          fwd_hit,
    output logic [31:0]   fwd_word,
    output logic          ld_stall,
    input  logic          mem_busy,
    output logic          dm_wr,
    output logic [2:0]    dm_ctrl,
    output logic [AW-1:0] dm_addr,
    output logic [31:0]   dm_data,
    output logic          empty
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    sb_entry_t         mem_q [DEPTH];
    logic [PW-1:0]     head_q, head_d;
    logic [PW-1:0]     tail_q, tail_d;
    logic [CW-1:0]     count_q, count_d;

    logic              full;
    logic              nonempty;
    logic              push;
    logic              pop;
    sb_entry_t         head_ent;

    logic [DEPTH-1:0][AW-3:0] ent_word;
    logic [DEPTH-1:0][31:0]   ent_data;
    logic [DEPTH-1:0][2:0]    ent_ctrl;

    // Byte offset does not matter for a word-granular match.
    logic              unused_ld_offset;
    assign unused_ld_offset = ^ld_addr[1:0];

    // Handshake and drain decisions; reset masks every request.
    always_comb begin
        full     = (count_q == CW'(DEPTH));
        nonempty = (count_q != '0);
        st_ready = rst | ~full;
        push     = ~rst & st_valid & ~full & dm_size_valid(st_ctrl);
        pop      = ~rst & nonempty & ~mem_busy;
        empty    = rst | ~nonempty;
        dm_wr    = pop;
    end

    // Data memory port is driven straight from the head entry.
    always_comb begin
        head_ent = mem_q[head_q];
        if (nonempty) begin
            dm_ctrl = head_ent.ctrl;
            dm_addr = head_ent.addr[AW-1:0];
            dm_data = head_ent.data;
        end else begin
            dm_ctrl = 3'b000;
            dm_addr = '0;
            dm_data = 32'h0;
        end
    end

    // Pointer and occupancy next state; pointers wrap naturally at DEPTH.
    always_comb begin
        head_d  = head_q + PW'(pop);
        tail_d  = tail_q + PW'(push);
        count_d = count_q + CW'(push) - CW'(pop);
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage; contents are only meaningful below count, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[tail_q] <= '{addr: SB_ADDR_MAX'(st_addr), data: st_data, ctrl: st_ctrl};
        end
    end

    // Flatten entries into per-field vectors for the matcher.
    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            ent_word[i] = mem_q[i].addr[AW-1:2];
            ent_data[i] = mem_q[i].data;
            ent_ctrl[i] = mem_q[i].ctrl;
        end
    end

    sb_match #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_match (
        .lookup_en (ld_valid & ~rst),
        .ld_word   (ld_addr[AW-1:2]),
        .head      (head_q),
        .count     (count_q),
        .ent_word  (ent_word),
        .ent_data  (ent_data),
        .ent_ctrl  (ent_ctrl),
        .fwd_hit   (fwd_hit),
        .fwd_word  (fwd_word),
        .ld_stall  (ld_stall)
    );

endmodule
